// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state type and address decode for the APB splitter
package apb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DERR} apb_state_e;
  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } apb_dec_t;
  function automatic apb_dec_t apb_decode(input logic [63:0] addr, input logic [63:0] base,
                                          input logic [63:0] n, input int sh);
    logic [63:0] slot;
    slot = (addr - base) >> sh;
    return '{hit: addr >= base && slot < n, idx: slot[3:0]};
  endfunction
endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: ACCESS wait-cycle counter, expired on the last permitted cycle
module apb_timeout_cnt #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(LIMIT);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= rst || clear ? '0 : enable ? cnt + CW'(1) : cnt;
  assign expired = cnt == CW'(LIMIT - 1);
endmodule

// File: rtl/apb_splitter.sv
// apb_splitter: one upstream APB port decoded onto NUM_APB_SLAVES slaves with decode/timeout errors
module apb_splitter
  import apb_pkg::*;
#(
  parameter int                          NUM_APB_SLAVES  = 4,
  parameter int                          APB_ADDR_WIDTH  = 32,
  parameter int                          APB_DATA_WIDTH  = 32,
  parameter logic [APB_ADDR_WIDTH-1:0]   BASE_ADDR       = 'h4000_0000,
  parameter int                          SLAVE_SPAN_LOG2 = 12,
  parameter int                          TIMEOUT_CYCLES  = 256
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      PSEL_s,
  input  logic                      PENABLE_s,
  input  logic                      PWRITE_s,
  input  logic                      PSTRB_s,
  input  logic                      PPROT_s,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR_s,
  input  logic [APB_DATA_WIDTH-1:0] PWDATA_s,
  output logic [APB_DATA_WIDTH-1:0] PRDATA_s,
  output logic                      PREADY_s,
  output logic                      PSLVERR_s,
  output logic [NUM_APB_SLAVES-1:0] PSEL_m,
  output logic [APB_ADDR_WIDTH-1:0] PADDR_m,
  output logic                      PWRITE_m,
  output logic [APB_DATA_WIDTH-1:0] PWDATA_m,
  output logic                      PENABLE_m,
  output logic                      PSTRB_m,
  output logic                      PPROT_m,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA_m [NUM_APB_SLAVES],
  input  logic [NUM_APB_SLAVES-1:0] PREADY_m,
  input  logic [NUM_APB_SLAVES-1:0] PSLVERR_m,
  output logic                      decode_err,
  output logic                      timeout_err,
  output logic [APB_ADDR_WIDTH-1:0] last_err_addr
);
  localparam int IW = $clog2(NUM_APB_SLAVES);
  apb_state_e    state;
  apb_dec_t      dec;
  logic [IW-1:0] idx, didx;
  logic          setup, act, derr, tout, expired;
  assign dec   = apb_decode(64'(PADDR_s), 64'(BASE_ADDR), 64'(NUM_APB_SLAVES), SLAVE_SPAN_LOG2);
  assign didx  = IW'(dec.idx);
  assign setup = state == IDLE && PSEL_s && !PENABLE_s;
  assign act   = state == ACCESS && PSEL_s;
  assign derr  = state == DERR && PSEL_s;
  // A slave answering on the very last allowed cycle wins over the timeout
  assign tout  = act && expired && !PREADY_m[idx];
  assign PSEL_m      = act ? NUM_APB_SLAVES'(1) << idx
                     : setup && dec.hit ? NUM_APB_SLAVES'(1) << didx : '0;
  assign PENABLE_m   = act && PENABLE_s;
  assign PREADY_s    = act ? PREADY_m[idx] || tout : derr;
  assign PSLVERR_s   = act ? PSLVERR_m[idx] || tout : derr;
  assign PRDATA_s    = act && !tout ? PRDATA_m[idx] : '0;
  assign decode_err  = derr;
  assign timeout_err = tout;
  assign PADDR_m     = PADDR_s;
  assign PWRITE_m    = PWRITE_s;
  assign PWDATA_m    = PWDATA_s;
  assign PSTRB_m     = PSTRB_s;
  assign PPROT_m     = PPROT_s;
  apb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_tcnt (
    .clk    (PCLK),
    .rst    (PRESET),
    .clear  (state != ACCESS),
    .enable (act && !PREADY_m[idx]),
    .expired(expired)
  );
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state         <= IDLE;
      idx           <= '0;
      last_err_addr <= '0;
    end else begin
      if (setup && dec.hit) idx <= didx;
      if (derr || tout) last_err_addr <= PADDR_s;
      state <= setup ? (dec.hit ? ACCESS : DERR)
             : act && !PREADY_m[idx] && !expired ? ACCESS : IDLE;
    end
  end
endmodule

// File: tb/tb_apb_splitter.sv
// tb_apb_splitter: directed and randomized transfers checked against a transaction-level model
module tb_apb_splitter;
  localparam int          N    = 4;
  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          T    = 8;
  localparam logic [31:0] BASE = 32'h4000_0000;
  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          PSEL_s, PENABLE_s, PWRITE_s, PSTRB_s, PPROT_s;
  logic [AW-1:0] PADDR_s;
  logic [DW-1:0] PWDATA_s, PRDATA_s;
  logic          PREADY_s, PSLVERR_s;
  logic [N-1:0]  PSEL_m;
  logic [AW-1:0] PADDR_m;
  logic          PWRITE_m, PENABLE_m, PSTRB_m, PPROT_m;
  logic [DW-1:0] PWDATA_m;
  logic [DW-1:0] PRDATA_m [N];
  logic [N-1:0]  PREADY_m, PSLVERR_m;
  logic          decode_err, timeout_err;
  logic [AW-1:0] last_err_addr;
  int            n_chk = 0;
  int            n_fail = 0;
  logic [31:0]   exp_last = '0;

  apb_splitter #(.TIMEOUT_CYCLES(T)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .PSEL_s(PSEL_s), .PENABLE_s(PENABLE_s), .PWRITE_s(PWRITE_s), .PSTRB_s(PSTRB_s),
    .PPROT_s(PPROT_s), .PADDR_s(PADDR_s), .PWDATA_s(PWDATA_s),
    .PRDATA_s(PRDATA_s), .PREADY_s(PREADY_s), .PSLVERR_s(PSLVERR_s),
    .PSEL_m(PSEL_m), .PADDR_m(PADDR_m), .PWRITE_m(PWRITE_m), .PWDATA_m(PWDATA_m),
    .PENABLE_m(PENABLE_m), .PSTRB_m(PSTRB_m), .PPROT_m(PPROT_m),
    .PRDATA_m(PRDATA_m), .PREADY_m(PREADY_m), .PSLVERR_m(PSLVERR_m),
    .decode_err(decode_err), .timeout_err(timeout_err), .last_err_addr(last_err_addr)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic noise;
    for (int i = 0; i < N; i++) begin
      PREADY_m[i]  = 1'($urandom);
      PSLVERR_m[i] = 1'($urandom);
      PRDATA_m[i]  = $urandom;
    end
  endtask

  task automatic idle_cycle;
    PSEL_s = 0;
    PENABLE_s = 0;
    noise();
    #2;
    chk("idle_psel", PSEL_m, 0);
    chk("idle_resp", {PREADY_s, PSLVERR_s, PENABLE_m, PRDATA_s}, 0);
    chk("idle_pulses", {decode_err, timeout_err}, 0);
    chk("idle_last", last_err_addr, exp_last);
    tick();
  endtask

  task automatic xfer(input logic [31:0] a, input logic wr, input int waits, input int abort_at);
    logic        map, rdy, tmo, err, done;
    logic [31:0] rd;
    int          sl;
    map = a >= BASE && ((a - BASE) / 4096) < N;
    sl  = map ? int'((a - BASE) / 4096) : 0;
    PSEL_s = 1; PENABLE_s = 0; PADDR_s = a; PWRITE_s = wr;
    PWDATA_s = $urandom; PSTRB_s = 1'($urandom); PPROT_s = 1'($urandom);
    noise();
    #2;
    chk("setup_psel", PSEL_m, map ? 64'(1) << sl : 0);
    chk("setup_resp", {PREADY_s, PSLVERR_s, PENABLE_m, PRDATA_s}, 0);
    chk("setup_pulses", {decode_err, timeout_err}, 0);
    chk("fwd_addr", PADDR_m, a);
    chk("fwd_ctl", {PWRITE_m, PSTRB_m, PPROT_m, PWDATA_m}, {wr, PSTRB_s, PPROT_s, PWDATA_s});
    chk("setup_last", last_err_addr, exp_last);
    tick();
    PENABLE_s = 1;
    done = 0;
    for (int k = 1; !done; k++) begin
      noise();
      if (k == abort_at) begin
        PSEL_s = 0; PENABLE_s = 0;
        #2;
        chk("abort_resp", {PREADY_s, PSLVERR_s, PENABLE_m}, 0);
        chk("abort_pulses", {decode_err, timeout_err}, 0);
        done = 1;
      end else if (!map) begin
        #2;
        chk("derr_psel", {PSEL_m, PENABLE_m}, 0);
        chk("derr_resp", {PREADY_s, PSLVERR_s}, 2'b11);
        chk("derr_rdata", PRDATA_s, 0);
        chk("derr_pulses", {decode_err, timeout_err}, 2'b10);
        exp_last = a;
        done = 1;
      end else begin
        rdy = (k - 1) == waits;
        tmo = !rdy && k == T;
        err = 1'($urandom);
        rd  = $urandom;
        PREADY_m[sl] = rdy; PSLVERR_m[sl] = err; PRDATA_m[sl] = rd;
        #2;
        chk("acc_psel", PSEL_m, 64'(1) << sl);
        chk("acc_penable", PENABLE_m, 1);
        chk("acc_ready", PREADY_s, rdy | tmo);
        chk("acc_slverr", PSLVERR_s, tmo | err);
        chk("acc_rdata", PRDATA_s, tmo ? 32'h0 : rd);
        chk("acc_pulses", {decode_err, timeout_err}, {1'b0, tmo});
        if (tmo) exp_last = a;
        done = rdy | tmo;
      end
      tick();
    end
    PSEL_s = 0;
    PENABLE_s = 0;
  endtask

  initial begin
    logic [31:0] a;
    PRESET = 1; PSEL_s = 0; PENABLE_s = 0; PWRITE_s = 0; PSTRB_s = 0; PPROT_s = 0;
    PADDR_s = '0; PWDATA_s = '0; PREADY_m = '0; PSLVERR_m = '0;
    for (int i = 0; i < N; i++) PRDATA_m[i] = '0;
    tick();
    tick();
    PRESET = 0;
    #2;
    chk("rst_psel", PSEL_m, 0);
    chk("rst_resp", {PREADY_s, PSLVERR_s, PENABLE_m, PRDATA_s}, 0);
    chk("rst_pulses", {decode_err, timeout_err}, 0);
    chk("rst_last", last_err_addr, 0);
    tick();
    xfer(32'h4000_1004, 1, 2, 0);
    idle_cycle();
    xfer(32'h4000_5000, 0, 0, 0);
    idle_cycle();
    xfer(32'h4000_2000, 0, 1000, 0);
    idle_cycle();
    xfer(32'h4000_0000, 1, 0, 0);
    xfer(32'h4000_3000, 0, 0, 0);
    xfer(32'h4000_0ffc, 0, T - 1, 0);
    xfer(32'h3fff_fffc, 1, 0, 0);
    xfer(32'h4000_4000, 1, 0, 0);
    idle_cycle();
    PSEL_s = 1; PENABLE_s = 0; PADDR_s = 32'h4000_1000; PREADY_m = '0;
    tick();
    PENABLE_s = 1;
    #2;
    chk("rst_mid_psel_before", PSEL_m, 4'b0010);
    PRESET = 1;
    tick();
    PRESET = 0;
    #2;
    chk("rst_mid_psel", {PSEL_m, PENABLE_m}, 0);
    chk("rst_mid_resp", {PREADY_s, PSLVERR_s, decode_err, timeout_err}, 0);
    chk("rst_mid_last", last_err_addr, 0);
    exp_last = '0;
    tick();
    idle_cycle();
    xfer(32'h4000_1008, 0, 0, 0);
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0: a = ($urandom_range(0, 1) == 0) ? $urandom_range(0, BASE - 1) : BASE + N * 4096 + $urandom_range(0, 32'h0fff_ffff);
        default: a = BASE + $urandom_range(0, N - 1) * 4096 + ($urandom_range(0, 4095) & ~32'h3);
      endcase
      xfer(a, 1'($urandom), $urandom_range(0, T + 2),
           $urandom_range(0, 7) == 0 ? $urandom_range(1, 3) : 0);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_splitter.md
APB_SPLITTER -- requirements
Module: apb_splitter

Interface
REQ-001 SHALL have parameter NUM_APB_SLAVES, default 4: number of downstream slave ports, 2..16.
REQ-002 SHALL have parameters APB_ADDR_WIDTH, default 32, and APB_DATA_WIDTH, default 32: bus widths.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h4000_0000: start of the decoded window.
REQ-004 SHALL have parameter SLAVE_SPAN_LOG2, default 12: log2 of the per-slave region size in bytes.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 256: maximum ACCESS cycles before abort, minimum 2.
REQ-006 SHALL have port PCLK  in  1: single clock; all logic on its rising edge.
REQ-007 SHALL have port PRESET  in  1: reset, synchronous and active-high.
REQ-008 SHALL have ports PSEL_s, PENABLE_s, PWRITE_s, PSTRB_s, PPROT_s  in  1 each: upstream APB request, driven by the mux master port.
REQ-009 SHALL have ports PADDR_s  in  APB_ADDR_WIDTH and PWDATA_s  in  APB_DATA_WIDTH: upstream address and write data.
REQ-010 SHALL have ports PRDATA_s  out  APB_DATA_WIDTH and PREADY_s, PSLVERR_s  out  1: upstream response.
REQ-011 SHALL have port PSEL_m  out  NUM_APB_SLAVES: one-hot slave select.
REQ-012 SHALL have ports PADDR_m, PWRITE_m, PWDATA_m, PENABLE_m, PSTRB_m, PPROT_m  out: widths as upstream, shared by all slaves.
REQ-013 SHALL have ports PRDATA_m  in  [NUM_APB_SLAVES] x APB_DATA_WIDTH and PREADY_m, PSLVERR_m  in  NUM_APB_SLAVES: slave responses.
REQ-014 SHALL have ports decode_err, timeout_err  out  1 each: single-cycle event pulses.
REQ-015 SHALL have port last_err_addr  out  APB_ADDR_WIDTH: PADDR_s of the most recent errored transfer.

Function
REQ-016 SHALL decode idx = (PADDR_s - BASE_ADDR) >> SLAVE_SPAN_LOG2; the address is mapped iff BASE_ADDR <= PADDR_s and idx < NUM_APB_SLAVES.
REQ-017 SHALL implement FSM states IDLE, ACCESS and DERR; reset state is IDLE.
REQ-018 IDLE: when PSEL_s=1 and PENABLE_s=0 and the address is mapped, SHALL assert PSEL_m[idx] in the same cycle (zero latency), register idx, clear the timeout counter and go to ACCESS.
REQ-019 IDLE: when PSEL_s=1 and PENABLE_s=0 and the address is unmapped, SHALL keep PSEL_m=0 and go to DERR.
REQ-020 ACCESS: SHALL hold PSEL_m[idx]=1 and set PENABLE_m=PENABLE_s, PREADY_s=PREADY_m[idx], PSLVERR_s=PSLVERR_m[idx] and PRDATA_s=PRDATA_m[idx].
REQ-021 ACCESS: when PREADY_m[idx]=1, SHALL go to IDLE next cycle; a setup phase in that next cycle is decoded normally, giving back-to-back transfers with no gap.
REQ-022 ACCESS: SHALL increment a counter of width $clog2(TIMEOUT_CYCLES) each cycle without PREADY_m[idx].
REQ-023 ACCESS: when the counter equals TIMEOUT_CYCLES-1 and PREADY_m[idx]=0, SHALL drive PREADY_s=1, PSLVERR_s=1 and PRDATA_s=0, pulse timeout_err and go to IDLE.
REQ-024 DERR: SHALL hold PSEL_m=0 and PENABLE_m=0, drive PREADY_s=1, PSLVERR_s=1 and PRDATA_s=0, pulse decode_err and go to IDLE.
REQ-025 SHALL drive PREADY_s=0, PSLVERR_s=0 and PRDATA_s=0 in IDLE.
REQ-026 SHALL forward PADDR_m, PWRITE_m, PWDATA_m, PSTRB_m and PPROT_m combinationally from upstream in all states.
REQ-027 SHALL hold PENABLE_m=0 outside ACCESS.
REQ-028 If PSEL_s drops during ACCESS or DERR, SHALL go to IDLE next cycle with no response and no error pulse.
REQ-029 When PREADY_m[idx]=1 and the counter reaches its limit in the same cycle, SHALL treat the transfer as a normal completion: no timeout pulse, slave PSLVERR passed through.
REQ-030 SHALL update last_err_addr on every decode_err or timeout_err pulse and hold it otherwise.
REQ-031 SHALL ignore PREADY_m and PSLVERR_m of unselected slaves.

Reset
REQ-032 On PRESET=1 at a PCLK edge, SHALL set the state to IDLE and clear idx, the counter and last_err_addr; all outputs are 0 the next cycle, including after a mid-transfer reset.

Structure
REQ-033 SHALL place the state enum and address-decode function in the shared package apb_pkg.
REQ-034 SHALL implement the timeout counter as sub-module apb_timeout_cnt, with inputs clear and enable and output expired.

Verification
REQ-035 Write to 0x4000_1004, slave 1 PREADY after 2 wait states -> PSEL_m=4'b0010, PREADY_s asserted in the 3rd ACCESS cycle, no error.
REQ-036 Read from 0x4000_5000 -> PSEL_m=0, PREADY_s=1 and PSLVERR_s=1 in the cycle after setup, decode_err pulse, last_err_addr=0x4000_5000.
REQ-037 Slave 2 never ready, TIMEOUT_CYCLES=8 -> PREADY_s=1 and PSLVERR_s=1 in the 8th ACCESS cycle, timeout_err pulse, PSEL_m=0 the next cycle.
REQ-038 Back-to-back transfers to slave 0 then slave 3, both with zero wait -> PSEL_m goes 0001 then 1000 with no idle cycle between.
REQ-039 PRESET asserted in ACCESS with slave 1 selected -> all PSEL_m, PENABLE_m and PREADY_s are 0 the next cycle, and the state is IDLE.
